// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and helpers for the scoreboarded register file
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ZERO      = 0;
    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_DEPTH = 32;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending-write bits, pending count and RAW hazard flags
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH),
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueRegister,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic              Hazard1,
    output logic              Hazard2,
    output logic [ADDR_W:0]   PendingCount
);

    // One bit per encodable address; bits at or above DEPTH are never set.
    localparam int                c_slots   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_one     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_regZero = ADDR_W'(REG_ZERO);

    logic [c_slots-1:0] r_pending;
    logic [c_slots-1:0] w_pendingNext;
    logic [ADDR_W:0]    r_count;
    logic [ADDR_W:0]    w_countNext;
    logic               w_issueValid;
    logic               w_wbValid;

    assign w_issueValid = IssueEn && (IssueRegister != c_regZero) && ({1'b0, IssueRegister} < c_depth);
    assign w_wbValid    = RegWrite && (WriteRegister != c_regZero) && ({1'b0, WriteRegister} < c_depth);

    // Clear first, then set, so an issue wins over a same-address writeback.
    always_comb begin
        w_pendingNext = r_pending;
        w_countNext   = r_count;
        if (w_wbValid && w_pendingNext[WriteRegister]) begin
            w_pendingNext[WriteRegister] = 1'b0;
            w_countNext                  = w_countNext - c_one;
        end
        if (w_issueValid && !w_pendingNext[IssueRegister]) begin
            w_pendingNext[IssueRegister] = 1'b1;
            w_countNext                  = w_countNext + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= '0;
            r_count   <= '0;
        end else if (Flush) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pendingNext;
            r_count   <= w_countNext;
        end
    end

    assign Hazard1 = r_pending[ReadRegister1] && (ReadRegister1 != c_regZero)
                     && !(BYPASS && RegWrite && (WriteRegister == ReadRegister1));
    assign Hazard2 = r_pending[ReadRegister2] && (ReadRegister2 != c_regZero)
                     && !(BYPASS && RegWrite && (WriteRegister == ReadRegister2));

    assign PendingCount = r_count;

endmodule
`default_nettype wire

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : register_file_sb
// Description : Parametrised register file, x0 hard-wired, optional bypass,
//               with a pending-write scoreboard for decode-stage stalls
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH),
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [N-1:0]      WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [N-1:0]      ReadData1,
    output logic [N-1:0]      ReadData2,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueRegister,
    input  logic              Flush,
    output logic              Hazard1,
    output logic              Hazard2,
    output logic [ADDR_W:0]   PendingCount
);

    // x0 has no storage; out-of-range addresses never match an entry.
    logic [N-1:0] r_regs [1:DEPTH-1];
    logic         w_bypass1;
    logic         w_bypass2;

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_reg
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_regs[i] <= '0;
                end else if (RegWrite && (WriteRegister == ADDR_W'(i))) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    endgenerate

    assign w_bypass1 = BYPASS && RegWrite && (WriteRegister == ReadRegister1);
    assign w_bypass2 = BYPASS && RegWrite && (WriteRegister == ReadRegister2);

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ReadRegister1 == ADDR_W'(i)) begin
                ReadData1 = w_bypass1 ? WriteData : r_regs[i];
            end
            if (ReadRegister2 == ADDR_W'(i)) begin
                ReadData2 = w_bypass2 ? WriteData : r_regs[i];
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .IssueEn       (IssueEn),
        .IssueRegister (IssueRegister),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .Flush         (Flush),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .Hazard1       (Hazard1),
        .Hazard2       (Hazard2),
        .PendingCount  (PendingCount)
    );

endmodule
`default_nettype wire
